// File: rtl/instr_writer.sv
// rtl/instr_writer.sv - Y86-64 instruction encoder writing one byte per clock into instruction memory
module instr_writer #(
  parameter int MEM_MAX_SIZE = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_addr_i,
  input  logic [63:0] start_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  icode_i,
  input  logic [3:0]  ifun_i,
  input  logic [3:0]  rA_i,
  input  logic [3:0]  rB_i,
  input  logic [63:0] valC_i,
  output logic        wr_en_o,
  output logic [63:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic [63:0] next_addr_o,
  output logic        busy_o,
  output logic        ins_err_o,
  output logic        adr_err_o
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [64:0] MEM_LIMIT = 65'(MEM_MAX_SIZE);

  state_t      state;
  logic [63:0] ptr;
  logic [3:0]  idx;
  logic [3:0]  len;
  logic [3:0]  l_icode, l_ifun, l_ra, l_rb;
  logic [63:0] l_valc;
  logic        l_regids;
  logic        ins_err, adr_err;

  logic        need_regids, need_valc, accept;
  logic [3:0]  in_len;
  logic [64:0] end_addr;
  logic [2:0]  vsel;
  logic [7:0]  cur_byte;

  always_comb begin
    need_regids = icode_i inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    need_valc   = icode_i inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    in_len      = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);
    // 65-bit sum so a pointer near 2^64 that wraps is still caught
    end_addr    = {1'b0, ptr} + {61'b0, in_len};
    in_ready_o  = (state == IDLE) && !load_addr_i && !rst_i;
    accept      = in_valid_i && in_ready_o;
  end

  // valC byte index relative to the start of the constant field
  assign vsel = idx[2:0] - (l_regids ? 3'd2 : 3'd1);

  always_comb begin
    cur_byte = l_valc[{vsel, 3'b000} +: 8];
    if (idx == 4'd0)
      cur_byte = {l_icode, l_ifun};
    else if (l_regids && idx == 4'd1)
      cur_byte = {l_ra, l_rb};
  end

  assign busy_o      = (state == EMIT);
  assign wr_en_o     = busy_o;
  assign wr_addr_o   = busy_o ? ptr : 64'd0;
  assign wr_data_o   = busy_o ? cur_byte : 8'd0;
  assign next_addr_o = ptr;
  assign ins_err_o   = ins_err;
  assign adr_err_o   = adr_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      ptr      <= 64'd0;
      idx      <= 4'd0;
      len      <= 4'd0;
      l_icode  <= 4'd0;
      l_ifun   <= 4'd0;
      l_ra     <= 4'd0;
      l_rb     <= 4'd0;
      l_valc   <= 64'd0;
      l_regids <= 1'b0;
      ins_err  <= 1'b0;
      adr_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_addr_i) begin
            ptr     <= start_addr_i;
            ins_err <= 1'b0;
            adr_err <= 1'b0;
          end else if (accept) begin
            if (icode_i >= 4'hC) begin
              ins_err <= 1'b1;
            end else if (end_addr > MEM_LIMIT) begin
              adr_err <= 1'b1;
            end else begin
              l_icode  <= icode_i;
              l_ifun   <= ifun_i;
              l_ra     <= rA_i;
              l_rb     <= rB_i;
              l_valc   <= valC_i;
              l_regids <= need_regids;
              len      <= in_len;
              idx      <= 4'd0;
              state    <= EMIT;
            end
          end
        end
        EMIT: begin
          ptr <= ptr + 64'd1;
          idx <= idx + 4'd1;
          if (idx == len - 4'd1)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_writer.sv
// tb/tb_instr_writer.sv - directed bench for instr_writer with a byte-stream reference model
module tb_instr_writer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        load_addr_i = 1'b0;
  logic [63:0] start_addr_i = 64'd0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [3:0]  icode_i = 4'd0, ifun_i = 4'd0, rA_i = 4'd0, rB_i = 4'd0;
  logic [63:0] valC_i = 64'd0;
  logic        wr_en_o;
  logic [63:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic [63:0] next_addr_o;
  logic        busy_o, ins_err_o, adr_err_o;

  instr_writer #(.MEM_MAX_SIZE(1024)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_addr_i(load_addr_i), .start_addr_i(start_addr_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .icode_i(icode_i), .ifun_i(ifun_i),
    .rA_i(rA_i), .rB_i(rB_i), .valC_i(valC_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .next_addr_o(next_addr_o), .busy_o(busy_o),
    .ins_err_o(ins_err_o), .adr_err_o(adr_err_o)
  );

  always #5 clk_i = ~clk_i;

  int vecs = 0;
  int errs = 0;
  int cycle = 0;
  bit run = 0;

  // model: pending bytes of the accepted instruction, final pointer, sticky flags
  logic [63:0] q_addr[$];
  logic [7:0]  q_data[$];
  logic [63:0] m_ptr = 64'd0;
  logic        m_ins = 1'b0, m_adr = 1'b0;

  // log of observed writes
  logic [63:0] l_addr[$];
  logic [7:0]  l_data[$];
  int          l_cyc[$];

  task automatic cmp(input string n, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cycle);
    end
  endtask

  initial begin
    logic exp_en;
    wait (run);
    forever begin
      @(negedge clk_i);
      #2;
      cycle++;
      exp_en = (q_addr.size() != 0);
      cmp("wr_en", {63'd0, wr_en_o}, {63'd0, exp_en});
      cmp("busy", {63'd0, busy_o}, {63'd0, exp_en});
      cmp("in_ready", {63'd0, in_ready_o}, {63'd0, !exp_en && !load_addr_i && !rst_i});
      cmp("next_addr", next_addr_o, m_ptr - 64'(q_addr.size()));
      cmp("ins_err", {63'd0, ins_err_o}, {63'd0, m_ins});
      cmp("adr_err", {63'd0, adr_err_o}, {63'd0, m_adr});
      if (exp_en) begin
        cmp("wr_addr", wr_addr_o, q_addr.pop_front());
        cmp("wr_data", {56'd0, wr_data_o}, {56'd0, q_data.pop_front()});
      end else begin
        cmp("wr_addr_idle", wr_addr_o, 64'd0);
        cmp("wr_data_idle", {56'd0, wr_data_o}, 64'd0);
      end
      if (wr_en_o) begin
        l_addr.push_back(wr_addr_o);
        l_data.push_back(wr_data_o);
        l_cyc.push_back(cycle);
      end
    end
  end

  task automatic log_clear();
    l_addr.delete(); l_data.delete(); l_cyc.delete();
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    int n;
    logic rdy;
    bit nr, nv;
    int len;
    logic [64:0] e;
    @(negedge clk_i);
    icode_i = ic; ifun_i = fn; rA_i = ra; rB_i = rb; valC_i = vc; in_valid_i = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy) begin
      #1;
      rdy = in_ready_o;
      @(posedge clk_i);
      if (!rdy) begin
        n++;
        if (n > 100) begin
          vecs++; errs++;
          $display("FAIL send_timeout: got ready 0 expected ready 1 within 100 cycles");
          in_valid_i = 1'b0;
          return;
        end
      end
    end
    #1;
    in_valid_i = 1'b0;
    nr = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    nv = ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    len = 1 + int'(nr) + 8 * int'(nv);
    e = {1'b0, m_ptr} + 65'(len);
    if (ic >= 4'hC) m_ins = 1'b1;
    else if (e > 65'd1024) m_adr = 1'b1;
    else begin
      q_addr.push_back(m_ptr); q_data.push_back({ic, fn});
      if (nr) begin q_addr.push_back(m_ptr + 64'd1); q_data.push_back({ra, rb}); end
      if (nv)
        for (int i = 0; i < 8; i++) begin
          q_addr.push_back(m_ptr + 64'(1 + int'(nr) + i));
          q_data.push_back(8'(vc >> (8 * i)));
        end
      m_ptr = m_ptr + 64'(len);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q_addr.size() != 0; i++) @(posedge clk_i);
    if (q_addr.size() != 0) begin
      vecs++; errs++;
      $display("FAIL drain_timeout: got %0d pending bytes expected 0", q_addr.size());
    end
  endtask

  task automatic load(input logic [63:0] a);
    @(negedge clk_i);
    load_addr_i = 1'b1; start_addr_i = a;
    @(posedge clk_i);
    #1;
    load_addr_i = 1'b0;
    m_ptr = a; m_ins = 1'b0; m_adr = 1'b0;
  endtask

  task automatic chk_log(input string n, input int k, input logic [63:0] a, input logic [7:0] d);
    if (k >= l_addr.size()) begin
      vecs++; errs++;
      $display("FAIL %s: got %0d writes expected more than %0d", n, l_addr.size(), k);
    end else begin
      cmp(n, l_addr[k], a);
      cmp(n, {56'd0, l_data[k]}, {56'd0, d});
    end
  endtask

  logic [7:0] irm_bytes [10] = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  logic [7:0] jmp_bytes [10] = '{8'h70, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    cmp("rst_wr_en", {63'd0, wr_en_o}, 64'd0);
    cmp("rst_ready_in_reset", {63'd0, in_ready_o}, 64'd0);
    cmp("rst_next_addr", next_addr_o, 64'd0);
    cmp("rst_flags", {62'd0, ins_err_o, adr_err_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #2;
    cmp("rst_ready", {63'd0, in_ready_o}, 64'd1);
    cmp("rst_busy", {63'd0, busy_o}, 64'd0);
    run = 1'b1;

    // irmovq at 0x100
    load(64'h100);
    log_clear();
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
    drain();
    for (int i = 0; i < 10; i++) chk_log("irmovq_byte", i, 64'h100 + 64'(i), irm_bytes[i]);
    cmp("irmovq_count", 64'(l_addr.size()), 64'd10);
    if (l_cyc.size() == 10) cmp("irmovq_span", 64'(l_cyc[9] - l_cyc[0]), 64'd9);
    @(negedge clk_i); #2;
    cmp("irmovq_next", next_addr_o, 64'h10A);

    // jmp then halt at 0
    load(64'h0);
    log_clear();
    send(4'h7, 4'h0, 4'h0, 4'h0, 64'h40);
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0);
    drain();
    for (int i = 0; i < 10; i++) chk_log("jmp_halt_byte", i, 64'(i), jmp_bytes[i]);
    @(negedge clk_i); #2;
    cmp("jmp_halt_next", next_addr_o, 64'hA);

    // back-to-back opq with one idle cycle between
    load(64'h0);
    log_clear();
    send(4'h6, 4'h0, 4'h2, 4'h3, 64'h0);
    send(4'h6, 4'h0, 4'h2, 4'h3, 64'h0);
    drain();
    chk_log("opq_b0", 0, 64'd0, 8'h60);
    chk_log("opq_b1", 1, 64'd1, 8'h23);
    chk_log("opq_b2", 2, 64'd2, 8'h60);
    chk_log("opq_b3", 3, 64'd3, 8'h23);
    if (l_cyc.size() == 4) cmp("opq_gap", 64'(l_cyc[2] - l_cyc[1]), 64'd2);

    // invalid icode, then nop, then clear
    @(negedge clk_i);
    log_clear();
    send(4'hC, 4'h0, 4'h0, 4'h0, 64'h0);
    @(negedge clk_i); #2;
    cmp("inv_flag", {63'd0, ins_err_o}, 64'd1);
    cmp("inv_ptr", next_addr_o, 64'd4);
    cmp("inv_nowrite", 64'(l_addr.size()), 64'd0);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    drain();
    chk_log("nop_byte", 0, 64'd4, 8'h10);
    load(64'h0);
    @(negedge clk_i); #2;
    cmp("inv_cleared", {63'd0, ins_err_o}, 64'd0);

    // address overflow and the last legal byte
    load(64'h3FC);
    log_clear();
    send(4'h4, 4'h0, 4'h1, 4'h2, 64'h0);
    @(negedge clk_i); #2;
    cmp("adr_flag", {63'd0, adr_err_o}, 64'd1);
    cmp("adr_nowrite", 64'(l_addr.size()), 64'd0);
    load(64'h3FF);
    send(4'h9, 4'h0, 4'h0, 4'h0, 64'h0);
    drain();
    chk_log("ret_byte", 0, 64'h3FF, 8'h90);
    @(negedge clk_i); #2;
    cmp("ret_next", next_addr_o, 64'h400);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    @(negedge clk_i); #2;
    cmp("full_adr_flag", {63'd0, adr_err_o}, 64'd1);
    load(64'hFFFF_FFFF_FFFF_FFFF);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
    @(negedge clk_i); #2;
    cmp("wrap_adr_flag", {63'd0, adr_err_o}, 64'd1);

    // reset in the middle of an instruction
    load(64'h20);
    log_clear();
    send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    q_addr.delete(); q_data.delete();
    m_ptr = 64'd0; m_ins = 1'b0; m_adr = 1'b0;
    cmp("rst_mid_wr_en", {63'd0, wr_en_o}, 64'd0);
    cmp("rst_mid_next", next_addr_o, 64'd0);
    cmp("rst_mid_count", 64'(l_addr.size()), 64'd3);
    @(negedge clk_i);
    rst_i = 1'b0;
    #2;
    cmp("rst_mid_ready", {63'd0, in_ready_o}, 64'd1);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #3;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/instr_writer.md
# instr_writer

Instruction encoder and writer for the Y86-64 instruction memory. It accepts one decoded instruction per handshake (icode, ifun, rA, rB, valC) and serializes it into the variable-length Y86 byte encoding. It emits one byte per clock on a byte-wide write port at an auto-incrementing address. It is the write-side counterpart of the fetch path and is used by the program loader and by benches to place programs into instruction memory.

## Interface
Parameters:
- MEM_MAX_SIZE, 1024: instruction memory size in bytes; the last writable address is MEM_MAX_SIZE-1.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- load_addr_i  in  1  load the write pointer from start_addr_i and clear the error flags; honoured only in IDLE.
- start_addr_i  in  64  new write-pointer value.
- in_valid_i  in  1  instruction fields are valid.
- in_ready_o  out  1  block can accept an instruction.
- icode_i / ifun_i / rA_i / rB_i  in  4 each  instruction fields.
- valC_i  in  64  constant word.
- wr_en_o  out  1  byte write strobe to instruction memory.
- wr_addr_o  out  64  byte address.
- wr_data_o  out  8  byte data.
- next_addr_o  out  64  current write pointer.
- busy_o  out  1  state is EMIT.
- ins_err_o  out  1  sticky flag: invalid icode was offered.
- adr_err_o  out  1  sticky flag: instruction would exceed memory.

## Operation
- States: IDLE and EMIT. Registers: state, ptr[63:0], idx[3:0], len[3:0], latched fields, and the two error flags.
- in_ready_o = (state==IDLE) && !load_addr_i && !rst_i.
- need_regids = icode in {2,3,4,5,6,A,B}. need_valC = icode in {3,4,5,7,8}. len = 1 + need_regids + 8*need_valC, so len is one of 1, 2, 9 or 10.
- Byte sequence:
  - byte0 = {icode, ifun}.
  - byte1 = {rA, rB}, only if need_regids.
  - Then valC in little-endian order (valC[7:0] first).
  - rA/rB are written as given. The block does not force 0xF.
- Accept (in_valid_i && in_ready_o at an edge):
  - icode >= 0xC: set ins_err_o, drop the instruction, stay in IDLE, ptr unchanged.
  - Else if {1'b0,ptr}+len > MEM_MAX_SIZE (65-bit compare, so 64-bit wrap counts as an error): set adr_err_o, drop, stay in IDLE.
  - Else latch the fields and len, set idx<=0, go to EMIT.
- EMIT:
  - wr_en_o=1, wr_addr_o=ptr, wr_data_o=byte[idx].
  - Each edge: ptr<=ptr+1 and idx<=idx+1.
  - When idx==len-1, go to IDLE.
- load_addr_i in IDLE: ptr<=start_addr_i, and ins_err_o/adr_err_o cleared. It takes priority over in_valid_i in the same cycle. It is ignored in EMIT.
- The error flags are sticky until load_addr_i or reset. Errors do not block later instructions.
- next_addr_o = ptr at all times. busy_o = (state==EMIT).

## Timing
- Reset values: state IDLE, ptr 0, idx 0, wr_en_o 0, wr_addr_o 0, wr_data_o 0, in_ready_o 1 (0 while rst_i is high), busy_o 0, both error flags 0, next_addr_o 0.
- Accept at edge E: byte k is presented in the cycle after edge E+k, for k=0..len-1.
- State is IDLE after edge E+len. The earliest next accept is edge E+len+1, so throughput is one instruction per len+1 cycles.
- wr_* outputs are derived from registers only and have no combinational path from inputs. wr_addr_o and wr_data_o are 0 when wr_en_o is 0.
- Rejected instructions consume one cycle and produce no write. The flag is visible the cycle after the accepting edge.
- rst_i during EMIT: the next cycle shows wr_en_o=0, ptr 0, and all state at reset values. The partially written instruction is abandoned.
- Boundary: ptr=MEM_MAX_SIZE-1 with len 1 is legal. The final write is at address MEM_MAX_SIZE-1, after which next_addr_o=MEM_MAX_SIZE.

## Test plan
- Reset, load 0x100, then irmovq (3,0,F,2, valC 0x0123456789ABCDEF) -> 10 writes at 0x100..0x109, data 30,F2,EF,CD,AB,89,67,45,23,01; next_addr_o=0x10A; in_ready_o low for 10 cycles.
- At addr 0: jmp (7,0, valC 0x40), then halt (0,0) -> writes 70,40,00×7 at 0..8, then 00 at 9; next_addr_o=0xA.
- in_valid_i held high with opq (6,0,2,3) twice -> bytes 60,23 at 0,1; one idle cycle; then 60,23 at 2,3; busy_o is 1 exactly during byte cycles.
- icode 0xC offered -> no wr_en_o, ins_err_o=1, ptr unchanged. A following nop (1,0) writes 10. load_addr_i clears ins_err_o.
- Load 0x3FC, then rmmovq (4,0,1,2, valC 0) -> adr_err_o=1, no writes. Load 0x3FF, then ret (9,0) -> write 90 at 0x3FF; next_addr_o=0x400.
- Load 0x20, irmovq in progress, rst_i asserted after the 3rd byte -> next cycle wr_en_o=0, next_addr_o=0, in_ready_o=1 after rst_i drops.
